// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline control bundle and widths for the RV32 pipeline registers
package pipe_pkg;

    localparam int D_WIDTH = 32;
    localparam int A_WIDTH = 5;

    typedef struct packed {
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic [2:0] ALUControl;
        logic       ALUSrc;
        logic       RegWrite;
        logic       Jump;
        logic       Branch;
        logic       JALRctrl;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-low reset
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - decode-to-execute pipeline register with stall, flush, valid and diagnostic counters
module id_ex_reg #(
    parameter int D_WIDTH   = pipe_pkg::D_WIDTH,
    parameter int A_WIDTH   = pipe_pkg::A_WIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ValidD,
    input  logic [1:0]           ResultSrcD,
    input  logic                 MemWriteD,
    input  logic [2:0]           ALUControlD,
    input  logic                 ALUSrcD,
    input  logic                 RegWriteD,
    input  logic                 JumpD,
    input  logic                 BranchD,
    input  logic                 JALRctrlD,
    input  logic [2:0]           fn3D,
    input  logic [D_WIDTH-1:0]   RD1D,
    input  logic [D_WIDTH-1:0]   RD2D,
    input  logic [D_WIDTH-1:0]   PCD,
    input  logic [D_WIDTH-1:0]   PCPlus4D,
    input  logic [D_WIDTH-1:0]   ImmExtD,
    input  logic [A_WIDTH-1:0]   Rs1D,
    input  logic [A_WIDTH-1:0]   Rs2D,
    input  logic [A_WIDTH-1:0]   RdD,
    output logic [1:0]           ResultSrcE,
    output logic                 MemWriteE,
    output logic [2:0]           ALUControlE,
    output logic                 ALUSrcE,
    output logic                 RegWriteE,
    output logic                 JumpE,
    output logic                 BranchE,
    output logic                 JALRctrlE,
    output logic [2:0]           fn3E,
    output logic [D_WIDTH-1:0]   RD1E,
    output logic [D_WIDTH-1:0]   RD2E,
    output logic [D_WIDTH-1:0]   PCE,
    output logic [D_WIDTH-1:0]   PCPlus4E,
    output logic [D_WIDTH-1:0]   ImmExtE,
    output logic [A_WIDTH-1:0]   Rs1E,
    output logic [A_WIDTH-1:0]   Rs2E,
    output logic [A_WIDTH-1:0]   RdE,
    output logic                 ValidE,
    output logic [CNT_WIDTH-1:0] BubbleCnt,
    output logic [CNT_WIDTH-1:0] StallCnt
);

    import pipe_pkg::*;

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    assign ctrl_d = '{ResultSrc:  ResultSrcD,
                      MemWrite:   MemWriteD,
                      ALUControl: ALUControlD,
                      ALUSrc:     ALUSrcD,
                      RegWrite:   RegWriteD,
                      Jump:       JumpD,
                      Branch:     BranchD,
                      JALRctrl:   JALRctrlD};

    // Bubbles clear the datapath too, so Rs/Rd of a bubble never hits a forwarding compare.
    always_ff @(posedge clk) begin
        if (!rst_n || FlushE) begin
            ctrl_q   <= CTRL_BUBBLE;
            ValidE   <= 1'b0;
            fn3E     <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            ImmExtE  <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
        end else if (!StallE) begin
            ctrl_q   <= ctrl_d;
            ValidE   <= ValidD;
            fn3E     <= fn3D;
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            ImmExtE  <= ImmExtD;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= RdD;
        end
    end

    assign ResultSrcE  = ctrl_q.ResultSrc;
    assign MemWriteE   = ctrl_q.MemWrite;
    assign ALUControlE = ctrl_q.ALUControl;
    assign ALUSrcE     = ctrl_q.ALUSrc;
    assign RegWriteE   = ctrl_q.RegWrite;
    assign JumpE       = ctrl_q.Jump;
    assign BranchE     = ctrl_q.Branch;
    assign JALRctrlE   = ctrl_q.JALRctrl;

    // A cycle with both flush and stall is a bubble, not a stall.
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (FlushE),
        .count (BubbleCnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (StallE && !FlushE),
        .count (StallCnt)
    );

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - table-driven directed bench for id_ex_reg
module tb_id_ex_reg;
    import pipe_pkg::*;

    localparam int CW = 4;

    typedef struct packed {
        logic        valid;
        ctrl_t       ctrl;
        logic [2:0]  fn3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } stage_t;

    typedef struct {
        logic          rst_n;
        logic          stall;
        logic          flush;
        stage_t        d;
        stage_t        exp;
        logic [CW-1:0] bcnt;
        logic [CW-1:0] scnt;
        string         name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, StallE, FlushE;
    stage_t din, dout;
    logic [CW-1:0] BubbleCnt, StallCnt;
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
        .ValidD(din.valid),
        .ResultSrcD(din.ctrl.ResultSrc), .MemWriteD(din.ctrl.MemWrite),
        .ALUControlD(din.ctrl.ALUControl), .ALUSrcD(din.ctrl.ALUSrc),
        .RegWriteD(din.ctrl.RegWrite), .JumpD(din.ctrl.Jump),
        .BranchD(din.ctrl.Branch), .JALRctrlD(din.ctrl.JALRctrl),
        .fn3D(din.fn3), .RD1D(din.rd1), .RD2D(din.rd2), .PCD(din.pc),
        .PCPlus4D(din.pcp4), .ImmExtD(din.imm),
        .Rs1D(din.rs1), .Rs2D(din.rs2), .RdD(din.rd),
        .ResultSrcE(dout.ctrl.ResultSrc), .MemWriteE(dout.ctrl.MemWrite),
        .ALUControlE(dout.ctrl.ALUControl), .ALUSrcE(dout.ctrl.ALUSrc),
        .RegWriteE(dout.ctrl.RegWrite), .JumpE(dout.ctrl.Jump),
        .BranchE(dout.ctrl.Branch), .JALRctrlE(dout.ctrl.JALRctrl),
        .fn3E(dout.fn3), .RD1E(dout.rd1), .RD2E(dout.rd2), .PCE(dout.pc),
        .PCPlus4E(dout.pcp4), .ImmExtE(dout.imm),
        .Rs1E(dout.rs1), .Rs2E(dout.rs2), .RdE(dout.rd),
        .ValidE(dout.valid), .BubbleCnt(BubbleCnt), .StallCnt(StallCnt)
    );

    function automatic stage_t mk(input int seed, input logic valid);
        stage_t s;
        logic [31:0] k;
        k = 32'(seed);
        s.valid           = valid;
        s.ctrl.ResultSrc  = k[1:0];
        s.ctrl.MemWrite   = 1'b1;
        s.ctrl.ALUControl = 3'(seed + 1);
        s.ctrl.ALUSrc     = k[0];
        s.ctrl.RegWrite   = 1'b1;
        s.ctrl.Jump       = k[1];
        s.ctrl.Branch     = k[2];
        s.ctrl.JALRctrl   = ~k[0];
        s.fn3             = 3'(seed + 2);
        s.rd1             = 32'h1000_0000 + k;
        s.rd2             = 32'h2000_0000 + k;
        s.pc              = 32'h0000_0400 + (k << 2);
        s.pcp4            = 32'h0000_0404 + (k << 2);
        s.imm             = 32'hFFFF_F000 | k;
        s.rs1             = 5'(seed + 1);
        s.rs2             = 5'(seed + 2);
        s.rd              = 5'(seed + 3);
        return s;
    endfunction

    function automatic vec_t v(input logic r, input logic st, input logic fl, input stage_t d,
                               input stage_t e, input int b, input int s, input string n);
        vec_t x;
        x.rst_n = r; x.stall = st; x.flush = fl; x.d = d; x.exp = e;
        x.bcnt = CW'(b); x.scnt = CW'(s); x.name = n;
        return x;
    endfunction

    task automatic chk_stage(input string n, input stage_t exp);
        checks++;
        if (dout === exp) passed++;
        else $display("FAIL %s stage: got %h required %h", n, dout, exp);
    endtask

    task automatic chk_cnt(input string n, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d required %0d", n, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t   tbl[$];
    stage_t zero, add_op;

    initial begin
        zero = '0;
        add_op = '0;
        add_op.valid = 1'b1;
        add_op.ctrl.RegWrite = 1'b1;
        add_op.rd  = 5'd5;
        add_op.rd1 = 32'h11;
        add_op.rd2 = 32'h22;

        // seed 4 gives RdD=7; seed 6 is loaded as an invalid slot
        tbl.push_back(v(0, 0, 0, mk(1, 1), zero,       0, 0, "reset_1"));
        tbl.push_back(v(0, 1, 1, mk(1, 1), zero,       0, 0, "reset_2_over_flush"));
        tbl.push_back(v(1, 0, 0, mk(1, 1), mk(1, 1),   0, 0, "load_after_reset"));
        tbl.push_back(v(1, 0, 0, add_op,   add_op,     0, 0, "pass_add"));
        tbl.push_back(v(1, 0, 0, mk(4, 1), mk(4, 1),   0, 0, "load_rd7"));
        tbl.push_back(v(1, 1, 0, mk(10, 1), mk(4, 1),  0, 1, "stall_1"));
        tbl.push_back(v(1, 1, 0, mk(11, 0), mk(4, 1),  0, 2, "stall_2"));
        tbl.push_back(v(1, 1, 0, mk(12, 1), mk(4, 1),  0, 3, "stall_3"));
        tbl.push_back(v(1, 0, 0, mk(12, 1), mk(12, 1), 0, 3, "stall_release"));
        tbl.push_back(v(1, 1, 1, mk(5, 1), zero,       1, 3, "flush_over_stall"));
        tbl.push_back(v(1, 0, 0, mk(6, 0), mk(6, 0),   1, 3, "load_invalid"));
        tbl.push_back(v(1, 0, 1, mk(7, 1), zero,       2, 3, "flush_only"));

        rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0; din = '0;
        #2;
        foreach (tbl[i]) begin
            rst_n  = tbl[i].rst_n;
            StallE = tbl[i].stall;
            FlushE = tbl[i].flush;
            din    = tbl[i].d;
            step();
            chk_stage(tbl[i].name, tbl[i].exp);
            chk_cnt({tbl[i].name, "_bubble"}, BubbleCnt, tbl[i].bcnt);
            chk_cnt({tbl[i].name, "_stall"}, StallCnt, tbl[i].scnt);
        end

        // Bubble counter saturation: starts at 2, steps to 15 and sticks.
        rst_n = 1'b1; StallE = 1'b0; FlushE = 1'b1; din = mk(9, 1);
        for (int i = 1; i <= 20; i++) begin
            step();
            chk_cnt($sformatf("bubble_sat_%0d", i), BubbleCnt, CW'((2 + i > 15) ? 15 : 2 + i));
        end
        chk_stage("bubble_sat_stage", zero);

        // Stall counter saturation from 3.
        FlushE = 1'b0;
        din = mk(3, 1);
        step();
        chk_stage("reload_before_stall", mk(3, 1));
        StallE = 1'b1;
        din = mk(8, 1);
        for (int i = 1; i <= 14; i++) begin
            step();
            chk_cnt($sformatf("stall_sat_%0d", i), StallCnt, CW'((3 + i > 15) ? 15 : 3 + i));
        end
        chk_stage("stall_sat_hold", mk(3, 1));

        // Reset in the middle of a stall clears everything; stall afterwards holds zeros.
        rst_n = 1'b0;
        step();
        chk_stage("reset_mid_stall", zero);
        chk_cnt("reset_mid_stall_bubble", BubbleCnt, 0);
        chk_cnt("reset_mid_stall_stall", StallCnt, 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            chk_stage($sformatf("post_reset_stall_%0d", i), zero);
            chk_cnt($sformatf("post_reset_stallcnt_%0d", i), StallCnt, CW'(i));
        end
        StallE = 1'b0;
        step();
        chk_stage("post_reset_release", mk(8, 1));
        chk_cnt("post_reset_bubble", BubbleCnt, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Decode-to-execute pipeline register of the pipelined RV32 core.
- Captures the control outputs of the decode-stage control unit together with the decode datapath values (register operands, PC, immediate, register indices).
- Presents them to the execute stage one cycle later.
- Implements stall (hold), flush (bubble insertion) and a valid bit, plus saturating bubble/stall counters for diagnostics.

Parameters:
- D_WIDTH, 32, datapath width (operands, PC, immediate).
- A_WIDTH, 5, register index width.
- CNT_WIDTH, 16, width of each diagnostic counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- StallE  in  1  hold all E-stage contents.
- FlushE  in  1  replace next E-stage contents with a bubble.
- ValidD  in  1  decode slot holds a real instruction.
- ResultSrcD  in  2  result mux select from decode.
- MemWriteD  in  1  store enable.
- ALUControlD  in  3  ALU operation.
- ALUSrcD  in  1  ALU B-operand select.
- RegWriteD  in  1  register-file write enable.
- JumpD  in  1  JAL/JALR.
- BranchD  in  1  conditional branch.
- JALRctrlD  in  1  JALR target select.
- fn3D  in  3  instr[14:12], for branch condition and load/store size.
- RD1D, RD2D  in  D_WIDTH  register-file read data.
- PCD, PCPlus4D, ImmExtD  in  D_WIDTH  PC, PC+4, extended immediate.
- Rs1D, Rs2D, RdD  in  A_WIDTH  register indices.
- All of the above with suffix E (ResultSrcE … RdE)  out  same widths  registered copies.
- ValidE  out  1  E-stage slot holds a real instruction.
- BubbleCnt  out  CNT_WIDTH  count of flush-inserted bubbles.
- StallCnt  out  CNT_WIDTH  count of stalled cycles.

Behaviour:
- Latency: one cycle from D inputs to E outputs when neither StallE nor FlushE is asserted.
- Reset (rst_n=0 at edge):
  - All E outputs 0, ValidE=0, both counters 0.
  - Overrides StallE/FlushE.
  - Reset asserted mid-stall or mid-flush leaves no residual state.
- Priority per edge: reset > FlushE > StallE > load.
- Load: every E register takes its D input; ValidE <= ValidD.
- Stall (StallE=1, FlushE=0): every E register, including ValidE, holds its value.
- Flush (FlushE=1), regardless of StallE:
  - Control outputs zeroed: RegWriteE, MemWriteE, JumpE, BranchE, JALRctrlE, ResultSrcE, ALUControlE, ALUSrcE all 0; ValidE <= 0.
  - Datapath outputs (RD1E, RD2E, PCE, PCPlus4E, ImmExtE, fn3E, Rs1E, Rs2E, RdE) are also zeroed, so a bubble never matches a forwarding comparison on a nonzero register.
- Bubble state is architecturally inert: no register write, no memory write, no PC redirect.
- ValidD=0 loads normally; D-stage control is already trusted to be inert for invalid slots, and no gating is applied here.
- BubbleCnt increments by 1 on every non-reset edge with FlushE=1.
- StallCnt increments on every non-reset edge with StallE=1 and FlushE=0.
- Both counters saturate at 2^CNT_WIDTH-1 (no wrap).
- Simultaneous FlushE and StallE counts as a bubble only.
- No combinational path from any input to any output; all outputs come straight from flops.

Decomposition:
- Shared package pipe_pkg:
  - struct ctrl_t {ResultSrc[1:0], MemWrite, ALUControl[2:0], ALUSrc, RegWrite, Jump, Branch, JALRctrl}.
  - localparam CTRL_BUBBLE = all-zero ctrl_t.
  - Width constants D_WIDTH and A_WIDTH, reused by the IF/ID and EX/MEM registers.
- One sub-module: sat_counter (CNT_WIDTH param; inc, clk, rst_n; saturating). Instantiated twice.

Test Plan:
- Reset: drive all D inputs nonzero with rst_n=0 for 2 cycles -> all E outputs, ValidE, BubbleCnt and StallCnt = 0. Release rst_n -> the next edge loads the D values.
- Pass-through: load ADD (ALUControlD=3'b000, RegWriteD=1, RdD=5, RD1D=0x11, RD2D=0x22, ValidD=1) -> identical values on E outputs exactly one edge later, ValidE=1.
- Stall: after loading RdD=7, hold StallE=1 for 3 cycles while changing D inputs -> RdE stays 7, ValidE stays 1, StallCnt=3. Deassert -> the current D values load.
- Flush, including priority: with RegWriteE=1/MemWriteE=1 held, assert FlushE=1 with StallE=1 for one cycle -> all E outputs 0, ValidE=0, BubbleCnt=1, StallCnt unchanged.
- Saturation: with CNT_WIDTH=4, assert FlushE for 20 cycles -> BubbleCnt reaches 15 and stays at 15.
- Reset mid-stall: StallE=1 holding a valid instruction, pulse rst_n=0 for one edge -> all outputs and counters 0. After release, with StallE still 1, outputs remain 0.
